// File: rtl/decode_pkg.sv
// Shared definitions for the decode/issue stage: default field widths,
// decode-info bit positions, opcode constants and the decode table.
package decode_pkg;

    // Default instruction format: {opc, f, rd, rs, imm}, MSB first
    localparam int W_OPC_D = 5;
    localparam int W_RD_D  = 5;
    localparam int W_IMM_D = 16;
    localparam int WORD_D  = W_OPC_D + 1 + 2 * W_RD_D + W_IMM_D;
    localparam int W_OPR_D = 32;
    localparam int ADDR_D  = 32;

    // Opcodes are decoded on a fixed-width view; narrower opcode fields are zero-extended
    localparam int OPC_MAX_W = 8;
    typedef logic [OPC_MAX_W-1:0] opc_t;

    localparam opc_t OPC_NOP  = 8'd0;  // no effect
    localparam opc_t OPC_ADD  = 8'd1;  // rd <= rd + rs
    localparam opc_t OPC_SUB  = 8'd2;  // rd <= rd - rs
    localparam opc_t OPC_LDI  = 8'd3;  // rd <= ext(imm), f selects sign extension
    localparam opc_t OPC_ADDI = 8'd4;  // rd <= rd + ext(imm), f selects sign extension
    localparam opc_t OPC_ST   = 8'd5;  // mem[rs + sext(imm)] <= rd
    localparam opc_t OPC_MOV  = 8'd6;  // rd <= rs

    // Decode-info vector bit positions
    localparam int DI_WRITES_RD = 4;
    localparam int DI_SIGN_EXT  = 3;
    localparam int DI_USE_IMM   = 2;
    localparam int DI_READS_RD  = 1;
    localparam int DI_READS_RS  = 0;
    localparam int DI_W         = 5;

    // Field offsets (LSB position) for a given rd/imm width
    function automatic int off_rs(input int w_imm);
        return w_imm;
    endfunction

    function automatic int off_rd(input int w_rd, input int w_imm);
        return w_imm + w_rd;
    endfunction

    function automatic int off_f(input int w_rd, input int w_imm);
        return w_imm + 2 * w_rd;
    endfunction

    function automatic int off_opc(input int w_rd, input int w_imm);
        return w_imm + 2 * w_rd + 1;
    endfunction

    // Decode table on {opc, f}; unknown opcodes behave as NOP
    function automatic logic [DI_W-1:0] decode_inst(input opc_t opc, input logic f);
        logic [DI_W-1:0] di;
        di = '0;
        case (opc)
            OPC_ADD, OPC_SUB: begin
                di[DI_WRITES_RD] = 1'b1;
                di[DI_READS_RD]  = 1'b1;
                di[DI_READS_RS]  = 1'b1;
            end
            OPC_LDI: begin
                di[DI_WRITES_RD] = 1'b1;
                di[DI_USE_IMM]   = 1'b1;
                di[DI_SIGN_EXT]  = f;
            end
            OPC_ADDI: begin
                di[DI_WRITES_RD] = 1'b1;
                di[DI_READS_RD]  = 1'b1;
                di[DI_USE_IMM]   = 1'b1;
                di[DI_SIGN_EXT]  = f;
            end
            OPC_ST: begin
                di[DI_READS_RD]  = 1'b1;
                di[DI_READS_RS]  = 1'b1;
                di[DI_USE_IMM]   = 1'b1;
                di[DI_SIGN_EXT]  = 1'b1;
            end
            OPC_MOV: begin
                di[DI_WRITES_RD] = 1'b1;
                di[DI_READS_RS]  = 1'b1;
            end
            default: di = '0;
        endcase
        return di;
    endfunction

endpackage

// File: rtl/decode_issue_sb_scoreboard.sv
// Register scoreboard: one busy bit per architectural register.
// Writeback clears, issue sets (set wins on the same register), r0 never busy.
// Two hazard-query ports optionally see a same-cycle writeback as already free.
module decode_issue_sb_scoreboard
    import decode_pkg::*;
#(
    parameter int W_RD      = W_RD_D,
    parameter bit BYPASS_WB = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr_v,
    input  logic [W_RD-1:0]      clr_r,
    input  logic                 set_v,
    input  logic [W_RD-1:0]      set_r,
    input  logic [W_RD-1:0]      q0_r,
    output logic                 q0_busy,
    input  logic [W_RD-1:0]      q1_r,
    output logic                 q1_busy,
    output logic [2**W_RD-1:0]   busy
);

    localparam int NREG = 2**W_RD;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] busy_eff;

    // Hazard view: optionally forward a writeback happening this cycle
    always_comb begin
        busy_eff = busy_q;
        if (BYPASS_WB && clr_v) begin
            busy_eff[clr_r] = 1'b0;
        end
    end

    assign q0_busy = busy_eff[q0_r];
    assign q1_busy = busy_eff[q1_r];
    assign busy    = busy_q;

    // Next state: clear first, then set, so a same-cycle clear+set leaves the bit busy
    always_comb begin
        busy_d = busy_q;
        if (clr_v) begin
            busy_d[clr_r] = 1'b0;
        end
        if (set_v && (set_r != '0)) begin
            busy_d[set_r] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy-bit register
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/decode_issue_sb.sv
// Decode/issue stage: one instruction held in ID, combinational regfile read,
// RAW/WAW hazard check against the internal scoreboard, registered EX slot.
module decode_issue_sb
    import decode_pkg::*;
#(
    parameter int WORD      = WORD_D,
    parameter int W_OPC     = W_OPC_D,
    parameter int W_RD      = W_RD_D,
    parameter int W_IMM     = W_IMM_D,
    parameter int W_OPR     = W_OPR_D,
    parameter int ADDR      = ADDR_D,
    parameter bit BYPASS_WB = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 v_i,
    output logic                 stall_o,
    input  logic [WORD-1:0]      inst_i,
    input  logic [ADDR-1:0]      pc_i,
    input  logic                 flush_i,
    output logic [W_RD-1:0]      r0_o,
    output logic [W_RD-1:0]      r1_o,
    input  logic [W_OPR-1:0]     r_opr0_i,
    input  logic [W_OPR-1:0]     r_opr1_i,
    input  logic                 wb_v_i,
    input  logic [W_RD-1:0]      wb_r_i,
    output logic                 v_o,
    input  logic                 stall_i,
    output logic [W_OPC-1:0]     opecode_o,
    output logic [W_OPR-1:0]     opr0_o,
    output logic [W_OPR-1:0]     opr1_o,
    output logic [W_OPR-1:0]     imm_o,
    output logic [W_RD-1:0]      wb_r_o,
    output logic                 wr_en_o,
    output logic [ADDR-1:0]      pc_o,
    output logic [2**W_RD-1:0]   busy_o
);

    localparam int OFF_RS  = off_rs(W_IMM);
    localparam int OFF_RD  = off_rd(W_RD, W_IMM);
    localparam int OFF_F   = off_f(W_RD, W_IMM);
    localparam int OFF_OPC = off_opc(W_RD, W_IMM);

    // Zero- or sign-extend the immediate to operand width
    function automatic logic [W_OPR-1:0] ext_imm(input logic [W_IMM-1:0] imm, input logic sx);
        logic [W_OPR-1:0] r;
        r = '0;
        r[W_IMM-1:0] = imm;
        for (int i = W_IMM; i < W_OPR; i++) begin
            r[i] = sx & imm[W_IMM-1];
        end
        return r;
    endfunction

    logic              vld_p0;
    logic [WORD-1:0]   inst_p0;
    logic [ADDR-1:0]   pc_p0;

    logic [W_OPC-1:0]  id_opc;
    logic              id_f;
    logic [W_RD-1:0]   id_rd;
    logic [W_RD-1:0]   id_rs;
    logic [W_IMM-1:0]  id_imm;
    logic [DI_W-1:0]   id_di;
    logic [W_OPR-1:0]  id_imm_ext;

    logic rd_busy;
    logic rs_busy;
    logic hazard;
    logic ex_hold;
    logic issue;

    // ---- stage p0 (ID): field split, decode, hazard and issue decision ----
    assign id_opc     = inst_p0[OFF_OPC +: W_OPC];
    assign id_f       = inst_p0[OFF_F];
    assign id_rd      = inst_p0[OFF_RD +: W_RD];
    assign id_rs      = inst_p0[OFF_RS +: W_RD];
    assign id_imm     = inst_p0[W_IMM-1:0];
    assign id_di      = decode_inst(opc_t'(id_opc), id_f);
    assign id_imm_ext = ext_imm(id_imm, id_di[DI_SIGN_EXT]);

    assign r0_o = id_rd;
    assign r1_o = id_rs;

    // rd is checked both as a source (RAW) and as a destination (WAW)
    assign hazard  = vld_p0 & (((id_di[DI_READS_RD] | id_di[DI_WRITES_RD]) & rd_busy)
                             | (id_di[DI_READS_RS] & rs_busy));
    assign ex_hold = v_o & stall_i;
    assign issue   = vld_p0 & ~hazard & ~ex_hold;
    assign stall_o = vld_p0 & ~issue;

    decode_issue_sb_scoreboard #(
        .W_RD      (W_RD),
        .BYPASS_WB (BYPASS_WB)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .clr_v   (wb_v_i),
        .clr_r   (wb_r_i),
        .set_v   (issue & id_di[DI_WRITES_RD]),
        .set_r   (id_rd),
        .q0_r    (id_rd),
        .q0_busy (rd_busy),
        .q1_r    (id_rs),
        .q1_busy (rs_busy),
        .busy    (busy_o)
    );

    // ID register: load whenever not stalling; flush kills whatever is in ID
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p0  <= 1'b0;
            inst_p0 <= '0;
            pc_p0   <= '0;
        end else begin
            if (!stall_o) begin
                vld_p0  <= v_i;
                inst_p0 <= inst_i;
                pc_p0   <= pc_i;
            end
            if (flush_i) begin
                vld_p0 <= 1'b0;
            end
        end
    end

    // ---- stage p1 (EX slot): registered issue outputs, held while downstream stalls ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            v_o       <= 1'b0;
            opecode_o <= '0;
            opr0_o    <= '0;
            opr1_o    <= '0;
            imm_o     <= '0;
            wb_r_o    <= '0;
            wr_en_o   <= 1'b0;
            pc_o      <= '0;
        end else begin
            if (!ex_hold) begin
                v_o       <= issue;
                opecode_o <= id_opc;
                opr0_o    <= r_opr0_i;
                opr1_o    <= id_di[DI_USE_IMM] ? id_imm_ext : r_opr1_i;
                imm_o     <= id_imm_ext;
                wb_r_o    <= id_rd;
                wr_en_o   <= id_di[DI_WRITES_RD];
                pc_o      <= pc_p0;
            end
            if (flush_i) begin
                v_o <= 1'b0;
            end
        end
    end

endmodule
